// File: rtl/logic_op_pkg.sv
// rtl/logic_op_pkg.sv - opcode constants shared by the logic-op scheduler and its logic unit
package logic_op_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_NAND = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_NOT  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
    localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

endpackage

// File: rtl/logic_unit.sv
// rtl/logic_unit.sv - combinational bitwise logic unit, one 2-input gate slice per bit
// Ports: op (opcode), a/b (operands, b unused for NOT) -> y (result, 0 when reserved), err (reserved opcode)
module logic_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    assign err = (op == OP_RSVD);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic and_o;
        logic or_o;
        logic xor_o;
        logic bit_y;

        // Only AND/OR/XOR gates per bit; the inverted ops reuse their outputs.
        assign and_o = a[gi] & b[gi];
        assign or_o  = a[gi] | b[gi];
        assign xor_o = a[gi] ^ b[gi];

        always_comb begin
            bit_y = 1'b0;
            case (op)
                OP_AND:  bit_y = and_o;
                OP_OR:   bit_y = or_o;
                OP_NAND: bit_y = ~and_o;
                OP_NOR:  bit_y = ~or_o;
                OP_NOT:  bit_y = ~a[gi];
                OP_XOR:  bit_y = xor_o;
                OP_XNOR: bit_y = ~xor_o;
                default: bit_y = 1'b0;
            endcase
        end

        assign y[gi] = bit_y;
    end

endmodule

// File: rtl/logic_op_scheduler.sv
// rtl/logic_op_scheduler.sv - round-robin sharing of one logic unit among NREQ requesters
// Ports: req_valid/req_ready/req_op/req_a/req_b (per-requester request channels),
//        rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_err (registered response), op_count (accept counter)
module logic_op_scheduler
    import logic_op_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [OP_W*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0]    req_a,
    input  logic [WIDTH*NREQ-1:0]    req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic [15:0]              op_count
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic [15:0]      count_q, count_d;

    logic             found;
    logic [IDW-1:0]   win;
    logic             slot_free;
    logic             accept;
    logic [OP_W-1:0]  sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] lu_y;
    logic             lu_err;

    // Rotating-priority search: first valid requester at or after ptr.
    always_comb begin
        int s;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            s = int'(ptr_q) + k;
            if (s >= NREQ) begin
                s = s - NREQ;
            end
            if (!found && req_valid[IDW'(s)]) begin
                found = 1'b1;
                win   = IDW'(s);
            end
        end
    end

    assign slot_free = !rsp_valid_q || rsp_ready;
    // rst_n gate keeps req_ready low while reset is held, when the slot otherwise looks free.
    assign accept    = found && slot_free && rst_n;
    assign req_ready = accept ? (NREQ'(1) << win) : '0;

    assign sel_op = req_op[int'(win)*OP_W +: OP_W];
    assign sel_a  = req_a[int'(win)*WIDTH +: WIDTH];
    assign sel_b  = req_b[int'(win)*WIDTH +: WIDTH];

    logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
        .op  (sel_op),
        .a   (sel_a),
        .b   (sel_b),
        .y   (lu_y),
        .err (lu_err)
    );

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        count_d     = count_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = win;
            rsp_data_d  = lu_err ? '0 : lu_y;
            rsp_err_d   = lu_err;
            ptr_d       = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
            count_d     = count_q + 16'd1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            count_q     <= count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign op_count  = count_q;

endmodule

// File: tb/tb_logic_op_scheduler.sv
// tb/tb_logic_op_scheduler.sv - self-checking bench for logic_op_scheduler
module tb_logic_op_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [3*NREQ-1:0]       req_op;
    logic [WIDTH*NREQ-1:0]   req_a;
    logic [WIDTH*NREQ-1:0]   req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [1:0]              rsp_id;
    logic [WIDTH-1:0]        rsp_data;
    logic                    rsp_err;
    logic [15:0]             op_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int              m_ptr;
    logic            m_valid;
    int              m_id;
    logic [7:0]      m_data;
    logic            m_err;
    logic [15:0]     m_count;
    logic [NREQ-1:0] exp_ready;
    int              exp_win;

    logic_op_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~(a & b);
            3'd3: return ~(a | b);
            3'd4: return ~a;
            3'd5: return a ^ b;
            3'd6: return ~(a ^ b);
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_id = 0; m_data = 0; m_err = 0; m_count = 0;
    endtask

    task automatic predict();
        exp_ready = '0;
        exp_win   = -1;
        if (!m_valid || rsp_ready) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (exp_win < 0 && req_valid[idx]) exp_win = idx;
            end
        end
        if (exp_win >= 0) exp_ready[exp_win] = 1'b1;
    endtask

    // Advance one clock and update the model with the inputs held across the edge.
    task automatic tick();
        logic [2:0] op;
        predict();
        @(posedge clk);
        if (exp_win >= 0) begin
            op      = req_op[3*exp_win +: 3];
            m_valid = 1'b1;
            m_id    = exp_win;
            m_data  = ref_op(op, req_a[8*exp_win +: 8], req_b[8*exp_win +: 8]);
            m_err   = (op == 3'd7);
            m_ptr   = (exp_win + 1) % NREQ;
            m_count = m_count + 16'd1;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid[i]      = v;
        req_op[3*i +: 3]  = op;
        req_a[8*i +: 8]   = a;
        req_b[8*i +: 8]   = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        model_reset();
        #2;
        n_checks++;
        if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err, op_count} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_state got v=%b id=%0d d=%h e=%b cnt=%0d exp all zero", rsp_valid, rsp_id, rsp_data, rsp_err, op_count);
        end
        rst_n = 1'b1;
        req_valid = '0;
        #1;
    endtask

    task automatic test_single();
        set_req(2, 1'b1, 3'd0, 8'hF0, 8'h3C);
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
        tick();
        req_valid = '0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'h30 || rsp_err !== 1'b0 || op_count !== 16'd1) begin
            n_fail++;
            $display("FAIL single_rsp got v=%b id=%0d d=%h e=%b cnt=%0d exp v=1 id=2 d=30 e=0 cnt=1",
                     rsp_valid, rsp_id, rsp_data, rsp_err, op_count);
        end
    endtask

    task automatic test_opcode_sweep();
        logic [7:0] exp_tab [8];
        exp_tab = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'h5A, 8'hAA, 8'h55, 8'h00};
        rsp_ready = 1'b1;
        for (int op = 0; op < 8; op++) begin
            set_req(0, 1'b1, 3'(op), 8'hA5, 8'h0F);
            tick();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== exp_tab[op] || rsp_err !== (op == 7)) begin
                n_fail++;
                $display("FAIL sweep_op%0d got v=%b id=%0d d=%h e=%b exp v=1 id=0 d=%h e=%b",
                         op, rsp_valid, rsp_id, rsp_data, rsp_err, exp_tab[op], (op == 7));
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        for (int c = 0; c < 12; c++) begin
            tick();
            n_checks++;
            if (rsp_valid !== 1'b1 || int'(rsp_id) != c % NREQ || rsp_data !== m_data) begin
                n_fail++;
                $display("FAIL rr_cycle%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h", c, rsp_valid, rsp_id, rsp_data, c % NREQ, m_data);
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_back_pressure();
        logic [7:0] d0;
        rsp_ready = 1'b0;
        req_valid = '0;
        set_req(0, 1'b1, 3'd5, 8'h3C, 8'h0F);
        tick();
        req_valid[0] = 1'b0;
        d0 = 8'h33;
        set_req(1, 1'b1, 3'd1, 8'h01, 8'h10);
        set_req(3, 1'b1, 3'd2, 8'hFF, 8'h0F);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready%0d got=%b exp=0000", c, req_ready); end
            tick();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== d0 || op_count !== m_count) begin
                n_fail++;
                $display("FAIL bp_hold%0d got v=%b id=%0d d=%h cnt=%0d exp v=1 id=0 d=%h cnt=%0d",
                         c, rsp_valid, rsp_id, rsp_data, op_count, d0, m_count);
            end
        end
        rsp_ready = 1'b1;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'h11) begin
            n_fail++; $display("FAIL bp_first got v=%b id=%0d d=%h exp v=1 id=1 d=11", rsp_valid, rsp_id, rsp_data);
        end
        req_valid[1] = 1'b0;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 8'hF0) begin
            n_fail++; $display("FAIL bp_second got v=%b id=%0d d=%h exp v=1 id=3 d=F0", rsp_valid, rsp_id, rsp_data);
        end
        req_valid = '0;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got v=%b exp v=0", rsp_valid); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                // A requester may only change its request when idle or just granted.
                if (!req_valid[i] || exp_win == i)
                    set_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            predict();
            n_checks++;
            if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready%0d got=%b exp=%b", c, req_ready, exp_ready); end
            tick();
            n_checks++;
            if (rsp_valid !== m_valid || op_count !== m_count ||
                (m_valid && (int'(rsp_id) != m_id || rsp_data !== m_data || rsp_err !== m_err))) begin
                n_fail++;
                $display("FAIL rand_rsp%0d got v=%b id=%0d d=%h e=%b cnt=%0d exp v=%b id=%0d d=%h e=%b cnt=%0d",
                         c, rsp_valid, rsp_id, rsp_data, rsp_err, op_count, m_valid, m_id, m_data, m_err, m_count);
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        rsp_ready = 1'b0;
        set_req(2, 1'b1, 3'd0, 8'hFF, 8'hAA);
        tick();
        req_valid = '0;
        n_checks++;
        if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_setup got v=%b exp v=1", rsp_valid); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 8'h00 || op_count !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reset got v=%b id=%0d d=%h cnt=%0d exp all zero", rsp_valid, rsp_id, rsp_data, op_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 3'd1, 8'(i), 8'h80);
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
        tick();
        n_checks++;
        if (rsp_id !== 2'd0 || rsp_data !== 8'h80) begin
            n_fail++; $display("FAIL mid_first_rsp got id=%0d d=%h exp id=0 d=80", rsp_id, rsp_data);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_counter_wrap();
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 3'd5, 8'h12, 8'h34);
        for (int c = 0; c < 65535; c++) @(posedge clk);
        #1;
        n_checks++;
        if (op_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_full got=%h exp=FFFF", op_count); end
        @(posedge clk);
        #1;
        n_checks++;
        if (op_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero got=%h exp=0000", op_count); end
        req_valid = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        exp_win   = -1;
        model_reset();
        test_reset();
        test_single();
        test_opcode_sweep();
        test_round_robin();
        test_back_pressure();
        test_random();
        test_reset_mid();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
